// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared types, widths and helpers for the L2 line cache
package l2_pkg;
    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_RESPOND
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction
endpackage

// File: rtl/l2_line_cache_if.sv
// rtl/l2_line_cache_if.sv - slow_memory-style line request/response bus
interface l2_line_cache_if;
    logic                      read;
    logic                      write;
    logic [31:4]               addr;
    logic [l2_pkg::LINE_W-1:0] wdata;
    logic [l2_pkg::LINE_W-1:0] rdata;
    logic                      ready;

    modport master (output read, write, addr, wdata, input rdata, ready);
    modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/l2_line_store.sv
// rtl/l2_line_store.sv - valid/dirty/tag/data arrays with one lookup and one write port
module l2_line_store
    import l2_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IW    = $clog2(LINES),
    parameter int TW    = ADDR_W - IW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IW-1:0]     rd_index,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TW-1:0]     rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_index,
    input  logic              wr_dirty,
    input  logic [TW-1:0]     wr_tag,
    input  logic [LINE_W-1:0] wr_data
);
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [TW-1:0]     tags [LINES];
    logic [LINE_W-1:0] data [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
            dirty[wr_index] <= wr_dirty;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_dirty = dirty[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];
endmodule

// File: rtl/l2_line_cache.sv
// rtl/l2_line_cache.sv - direct-mapped write-back L2 between the L1 port and slow_memory
module l2_line_cache
    import l2_pkg::*;
#(
    parameter int LINES = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    l2_line_cache_if.slave   p,
    l2_line_cache_if.master  m,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - IW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_n;
    logic              req_write, req_write_n;
    logic [31:4]       req_addr, req_addr_n;
    logic [LINE_W-1:0] req_wdata, req_wdata_n;
    logic              p_ready_q, p_ready_n;
    logic [LINE_W-1:0] p_rdata_q, p_rdata_n;
    logic              m_read_q, m_read_n, m_write_q, m_write_n;
    logic [31:4]       m_addr_q, m_addr_n;
    logic [LINE_W-1:0] m_wdata_q, m_wdata_n;
    logic [CNT_W-1:0]  hit_cnt_n, miss_cnt_n;

    logic [IW-1:0]     req_index;
    logic [TW-1:0]     req_tag;
    logic              rd_valid, rd_dirty, hit;
    logic [TW-1:0]     rd_tag;
    logic [LINE_W-1:0] rd_data;
    logic              wr_en, wr_dirty;
    logic [TW-1:0]     wr_tag;
    logic [LINE_W-1:0] wr_data;

    assign req_index = req_addr[IW+3:4];
    assign req_tag   = req_addr[31:IW+4];
    assign hit       = rd_valid && (rd_tag == req_tag);

    l2_line_store #(.LINES(LINES)) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (req_index),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (req_index),
        .wr_dirty (wr_dirty),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    always_comb begin
        state_n     = state;
        req_write_n = req_write;
        req_addr_n  = req_addr;
        req_wdata_n = req_wdata;
        p_ready_n   = 1'b0;
        p_rdata_n   = p_rdata_q;
        m_read_n    = m_read_q;
        m_write_n   = m_write_q;
        m_addr_n    = m_addr_q;
        m_wdata_n   = m_wdata_q;
        hit_cnt_n   = hit_cnt;
        miss_cnt_n  = miss_cnt;
        wr_en       = 1'b0;
        wr_dirty    = 1'b1;
        wr_tag      = req_tag;
        wr_data     = req_wdata;
        case (state)
            S_IDLE: begin
                // Both read and write asserted is resolved as a write.
                if (p.read || p.write) begin
                    req_write_n = p.write;
                    req_addr_n  = p.addr;
                    req_wdata_n = p.wdata;
                    state_n     = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    hit_cnt_n = CNT_W'(sat_inc(32'(hit_cnt), 32'(CNT_MAX)));
                    if (req_write) wr_en = 1'b1;
                    else           p_rdata_n = rd_data;
                    p_ready_n = 1'b1;
                    state_n   = S_RESPOND;
                end else begin
                    miss_cnt_n = CNT_W'(sat_inc(32'(miss_cnt), 32'(CNT_MAX)));
                    if (rd_valid && rd_dirty) begin
                        m_write_n = 1'b1;
                        m_addr_n  = {rd_tag, req_index};
                        m_wdata_n = rd_data;
                        state_n   = S_WRITEBACK;
                    end else if (!req_write) begin
                        m_read_n = 1'b1;
                        m_addr_n = req_addr;
                        state_n  = S_ALLOCATE;
                    end else begin
                        wr_en     = 1'b1;
                        p_ready_n = 1'b1;
                        state_n   = S_RESPOND;
                    end
                end
            end
            S_WRITEBACK: begin
                if (m.ready) begin
                    m_write_n = 1'b0;
                    wr_en     = 1'b1;
                    if (req_write) begin
                        p_ready_n = 1'b1;
                        state_n   = S_RESPOND;
                    end else begin
                        // Victim stays resident but clean until the refill lands.
                        wr_dirty = 1'b0;
                        wr_tag   = rd_tag;
                        wr_data  = rd_data;
                        m_read_n = 1'b1;
                        m_addr_n = req_addr;
                        state_n  = S_ALLOCATE;
                    end
                end
            end
            S_ALLOCATE: begin
                if (m.ready) begin
                    m_read_n  = 1'b0;
                    wr_en     = 1'b1;
                    wr_dirty  = 1'b0;
                    wr_data   = m.rdata;
                    p_rdata_n = m.rdata;
                    p_ready_n = 1'b1;
                    state_n   = S_RESPOND;
                end
            end
            S_RESPOND: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            p_ready_q <= 1'b0;
            p_rdata_q <= '0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_n;
            req_write <= req_write_n;
            req_addr  <= req_addr_n;
            req_wdata <= req_wdata_n;
            p_ready_q <= p_ready_n;
            p_rdata_q <= p_rdata_n;
            m_read_q  <= m_read_n;
            m_write_q <= m_write_n;
            m_addr_q  <= m_addr_n;
            m_wdata_q <= m_wdata_n;
            hit_cnt   <= hit_cnt_n;
            miss_cnt  <= miss_cnt_n;
        end
    end

    assign p.ready = p_ready_q;
    assign p.rdata = p_rdata_q;
    assign m.read  = m_read_q;
    assign m.write = m_write_q;
    assign m.addr  = m_addr_q;
    assign m.wdata = m_wdata_q;
endmodule
